// File: rtl/tri_raster_n.sv
// tri_raster_n: N-triangle scan-line rasteriser, per-pixel edge/barycentric stepping with priority coverage.
// Define TRI_RASTER_BACKFACE_EN to treat reversed-winding triangles as hits shaded with back_color.
module tri_raster_n #(
    parameter int NUM_TRI  = 2,
    parameter int EW       = 20,
    parameter int BW       = 22,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic [1:0]              render_mode,
    input  logic [NUM_TRI*3*EW-1:0] e_init,
    input  logic [NUM_TRI*3*EW-1:0] e_dx,
    input  logic [NUM_TRI*2*BW-1:0] b_init,
    input  logic [NUM_TRI*2*BW-1:0] b_dx,
    input  logic [NUM_TRI*6-1:0]    tri_color,
    input  logic [5:0]              back_color,
    input  logic [5:0]              bg_color,
    input  logic                    texel,
    output logic [6:0]              tex_u,
    output logic [6:0]              tex_v,
    output logic [5:0]              rgb,
    output logic                    hit,
    output logic [2:0]              tri_idx,
    output logic                    back_face
);
    localparam int NE = 3 * NUM_TRI;
    localparam int NB = 2 * NUM_TRI;

    logic [EW-1:0]      r_e [NE];
    logic [BW-1:0]      r_b [NB];
    logic [BW-1:0]      w_b_next [NB];
    logic               r_phase, r_miss, r_back;
    logic [2:0]         r_win;
    logic [6:0]         r_tex_u, r_tex_v;
    logic [5:0]         r_rgb;
    logic               r_hit, r_bf;
    logic [2:0]         r_idx;
    logic [NUM_TRI-1:0] w_front, w_back;
    logic               w_active, w_line_load, w_frame_load;
    logic               w_found, w_wback;
    logic [2:0]         w_win;
    logic [6:0]         w_tu, w_tv;
    logic [5:0]         w_tcol, w_shade;

    assign w_active     = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
    assign w_line_load  = (x == 10'(H_TOTAL - 1)) && (y < 10'(V_ACTIVE));
    assign w_frame_load = (x == 10'(H_TOTAL - 1)) && (y == 10'(V_TOTAL - 1));

    for (genvar i = 0; i < NB; i++) begin : g_b
        assign w_b_next[i] = r_b[i] + b_dx[i*BW +: BW];
    end

    // A zero edge is outside for both windings: front needs all negative, back all strictly positive.
    for (genvar t = 0; t < NUM_TRI; t++) begin : g_cov
        assign w_front[t] = r_e[3*t][EW-1] & r_e[3*t+1][EW-1] & r_e[3*t+2][EW-1];
`ifdef TRI_RASTER_BACKFACE_EN
        assign w_back[t] = ~r_e[3*t][EW-1]   & (|r_e[3*t])
                         & ~r_e[3*t+1][EW-1] & (|r_e[3*t+1])
                         & ~r_e[3*t+2][EW-1] & (|r_e[3*t+2]);
`else
        assign w_back[t] = 1'b0;
`endif
    end

    // Scan from the highest index down so the lowest covering triangle wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_wback = 1'b0;
        w_tu    = w_b_next[1][BW-3 -: 7];
        w_tv    = w_b_next[0][BW-3 -: 7];
        for (int t = NUM_TRI - 1; t >= 0; t--)
            if (w_front[t] || w_back[t]) begin
                w_found = 1'b1;
                w_win   = 3'(t);
                w_wback = ~w_front[t];
                w_tu    = w_b_next[2*t+1][BW-3 -: 7];
                w_tv    = w_b_next[2*t][BW-3 -: 7];
            end
    end

    always_comb begin
        w_tcol = tri_color[5:0];
        for (int t = 1; t < NUM_TRI; t++)
            if (r_win == 3'(t)) w_tcol = tri_color[6*t +: 6];
    end

    assign w_shade = r_miss                ? bg_color :
                     r_back                ? back_color :
                     render_mode == 2'd0   ? w_tcol :
                     render_mode == 2'd1   ? (texel ? w_tcol : bg_color) :
                     render_mode == 2'd2   ? {r_tex_u[6:4], r_tex_v[6:4]} : 6'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NE; i++) r_e[i] <= '0;
            for (int i = 0; i < NB; i++) r_b[i] <= '0;
            r_phase <= 1'b1;
            r_miss  <= 1'b1;
            r_back  <= 1'b0;
            r_win   <= '0;
            r_tex_u <= '0;
            r_tex_v <= '0;
            r_rgb   <= '0;
            r_hit   <= 1'b0;
            r_idx   <= '0;
            r_bf    <= 1'b0;
        end else if (!w_active) begin
            r_rgb <= '0;
            r_hit <= 1'b0;
            if (w_line_load || w_frame_load) begin
                for (int i = 0; i < NE; i++) r_e[i] <= e_init[i*EW +: EW];
                for (int i = 0; i < NB; i++) r_b[i] <= b_init[i*BW +: BW];
                r_miss <= 1'b1;
                r_back <= 1'b0;
                r_win  <= '0;
                if (w_frame_load) r_phase <= 1'b1;
            end
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                for (int i = 0; i < NB; i++) r_b[i] <= w_b_next[i];
                r_win   <= w_win;
                r_back  <= w_wback;
                r_miss  <= ~w_found;
                r_tex_u <= w_tu;
                r_tex_v <= w_tv;
            end else begin
                for (int i = 0; i < NE; i++) r_e[i] <= r_e[i] + e_dx[i*EW +: EW];
                r_rgb <= w_shade;
                r_hit <= ~r_miss;
                r_idx <= r_win;
                r_bf  <= r_back;
            end
        end
    end

    assign tex_u     = r_tex_u;
    assign tex_v     = r_tex_v;
    assign rgb       = r_rgb;
    assign hit       = r_hit;
    assign tri_idx   = r_idx;
    assign back_face = r_bf;
endmodule

// File: tb/tb_tri_raster_n.sv
// tb_tri_raster_n: scoreboard bench for tri_raster_n on a reduced raster; expected pixels come from
// a closed-form model (pixel p shows coverage of init + p*dx, pixel 0 of each line is a seeded miss).
module tb_tri_raster_n;
    localparam int NT = 2, EW = 20, BW = 22, HA = 32, VA = 8, HT = 40, VT = 10;

    logic clk = 1'b0, reset = 1'b1, texel = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic [1:0] render_mode = '0;
    logic [NT*3*EW-1:0] e_init, e_dx;
    logic [NT*2*BW-1:0] b_init, b_dx;
    logic [NT*6-1:0] tri_color;
    logic [5:0] back_color = '0, bg_color = '0;
    logic [6:0] tex_u, tex_v;
    logic [5:0] rgb;
    logic hit, back_face;
    logic [2:0] tri_idx;

    int ei[NT*3], ed[NT*3], bi[NT*2], bd[NT*2];
    logic [5:0] tc[NT];
    int n_tests = 0, n_fail = 0;
    bit dead = 1'b0;

    typedef struct {
        logic [5:0] rgb;
        logic       hit;
        logic [2:0] idx;
        logic       bf;
        logic [6:0] tu, tv;
        bit         tex;
    } exp_t;
    exp_t sb[$];

    tri_raster_n #(.NUM_TRI(NT), .EW(EW), .BW(BW), .H_ACTIVE(HA), .V_ACTIVE(VA),
                   .H_TOTAL(HT), .V_TOTAL(VT)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .render_mode(render_mode),
        .e_init(e_init), .e_dx(e_dx), .b_init(b_init), .b_dx(b_dx),
        .tri_color(tri_color), .back_color(back_color), .bg_color(bg_color), .texel(texel),
        .tex_u(tex_u), .tex_v(tex_v), .rgb(rgb), .hit(hit), .tri_idx(tri_idx), .back_face(back_face)
    );

    always #5 clk = ~clk;

    always_comb begin
        e_init = '0; e_dx = '0; b_init = '0; b_dx = '0; tri_color = '0;
        for (int i = 0; i < NT*3; i++) begin
            e_init[i*EW +: EW] = EW'(ei[i]);
            e_dx[i*EW +: EW]   = EW'(ed[i]);
        end
        for (int i = 0; i < NT*2; i++) begin
            b_init[i*BW +: BW] = BW'(bi[i]);
            b_dx[i*BW +: BW]   = BW'(bd[i]);
        end
        for (int t = 0; t < NT; t++) tri_color[6*t +: 6] = tc[t];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(int p);
        exp_t r;
        logic [EW-1:0] v;
        logic [BW-1:0] b1, b2;
        bit f, bk;
        r = '{rgb: bg_color, hit: 1'b0, idx: 3'd0, bf: 1'b0, tu: 7'd0, tv: 7'd0, tex: 1'b0};
        if (p == 0 || dead) return r;
        for (int t = 0; t < NT; t++) begin
            f = 1'b1; bk = 1'b1;
            for (int k = 0; k < 3; k++) begin
                v  = EW'(ei[3*t+k] + p * ed[3*t+k]);
                f  = f & ($signed(v) < 0);
                bk = bk & ($signed(v) > 0);
            end
`ifndef TRI_RASTER_BACKFACE_EN
            bk = 1'b0;
`endif
            if (f || bk) begin
                b1 = BW'(bi[2*t] + p * bd[2*t]);
                b2 = BW'(bi[2*t+1] + p * bd[2*t+1]);
                r.hit = 1'b1; r.idx = 3'(t); r.bf = bk;
                r.tu = b2[BW-3 -: 7]; r.tv = b1[BW-3 -: 7];
                r.rgb = bk ? back_color :
                        render_mode == 2'd0 ? tc[t] :
                        render_mode == 2'd1 ? (texel ? tc[t] : bg_color) :
                        render_mode == 2'd2 ? {r.tu[6:4], r.tv[6:4]} : 6'd0;
                return r;
            end
        end
        return r;
    endfunction

    // One pixel = two clocks; the output is sampled after its second edge. With rst, reset is
    // held across that second edge so every output must show its reset value.
    task automatic pix(input int px, input int py, input bit rst);
        exp_t e, nx;
        x = 10'(px); y = 10'(py);
        if (rst) e = '{rgb: 6'd0, hit: 1'b0, idx: 3'd0, bf: 1'b0, tu: 7'd0, tv: 7'd0, tex: 1'b1};
        else if (px >= HA || py >= VA) e = '{rgb: 6'd0, hit: 1'b0, idx: 3'd0, bf: 1'b0, tu: 7'd0, tv: 7'd0, tex: 1'b0};
        else begin
            e = model(px);
            nx = model(px + 1);
            e.tex = nx.hit; e.tu = nx.tu; e.tv = nx.tv;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        if (rst) reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        e = sb.pop_front();
        chk($sformatf("rgb@%0d,%0d", px, py), 32'(rgb), 32'(e.rgb));
        chk($sformatf("hit@%0d,%0d", px, py), 32'(hit), 32'(e.hit));
        if (e.hit || rst) begin
            chk($sformatf("idx@%0d,%0d", px, py), 32'(tri_idx), 32'(e.idx));
            chk($sformatf("bf@%0d,%0d", px, py), 32'(back_face), 32'(e.bf));
        end
        if (e.tex) begin
            chk($sformatf("tex_u@%0d,%0d", px, py), 32'(tex_u), 32'(e.tu));
            chk($sformatf("tex_v@%0d,%0d", px, py), 32'(tex_v), 32'(e.tv));
        end
        if (rst) dead = 1'b1;
    endtask

    // A line starts with the previous line's load pixel (x=HT-1), exactly as the VGA counter orders it.
    task automatic line(input int ly, input int rst_x);
        int py;
        py = (ly == 0) ? VT - 1 : ly - 1;
        pix(HT - 1, py, 1'b0);
        if (py < VA || py == VT - 1) dead = 1'b0;
        for (int i = 0; i < HT - 1; i++) pix(i, ly, i == rst_x);
    endtask

    task automatic set_flat();
        for (int i = 0; i < NT*3; i++) begin ei[i] = -5; ed[i] = 0; end
        for (int i = 0; i < NT*2; i++) begin bi[i] = 0; bd[i] = 0; end
        tc[0] = 6'h30; tc[1] = 6'h0C; render_mode = 2'd0;
    endtask

    initial begin
        for (int i = 0; i < NT*3; i++) begin ei[i] = 0; ed[i] = 0; end
        for (int i = 0; i < NT*2; i++) begin bi[i] = 0; bd[i] = 0; end
        for (int t = 0; t < NT; t++) tc[t] = '0;
        bg_color = 6'h15; back_color = 6'h2A;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_idx", 32'(tri_idx), 0);
        chk("rst_bf", 32'(back_face), 0);
        chk("rst_tex_u", 32'(tex_u), 0);
        chk("rst_tex_v", 32'(tex_v), 0);
        reset = 1'b0;

        for (int ly = 0; ly < VT; ly++) line(ly, -1);

        set_flat();
        line(0, -1);
        line(1, -1);

        ei[0] = -3; ed[0] = 1;
        for (int k = 3; k < 6; k++) ei[k] = 0;
        line(2, -1);
        line(3, -1);

        set_flat();
        bi[1] = 32'h0008_0000; render_mode = 2'd1; texel = 1'b1;
        line(4, -1);
        texel = 1'b0;
        line(5, -1);
        bi[1] = 0; bd[1] = 1 << 15; bd[0] = 1 << 14; render_mode = 2'd2;
        line(6, -1);
        render_mode = 2'd3;
        line(7, -1);

        set_flat();
        for (int k = 0; k < 3; k++) ei[k] = 7;
        line(1, -1);

        set_flat();
        line(3, 20);
        line(4, -1);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NT*3; i++) begin
                ei[i] = int'($urandom_range(0, 80)) - 40;
                ed[i] = int'($urandom_range(0, 6)) - 3;
            end
            for (int i = 0; i < NT*2; i++) begin
                bi[i] = int'($urandom_range(0, (1 << 22) - 1));
                bd[i] = int'($urandom_range(0, 1 << 16));
            end
            for (int t = 0; t < NT; t++) tc[t] = 6'($urandom_range(0, 63));
            render_mode = 2'($urandom_range(0, 3));
            texel = 1'($urandom_range(0, 1));
            line(n % VA, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
